// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the shared-ALU, shared-memory multicycle RV32I datapath.
// Latency: branch 3, ALU/lui/auipc/jal/sw 4, lw 5 cycles; +1 per mem_ready-low cycle in FETCH/MEMREAD/MEMWRITE.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; other states ignore it.
module multicycle_ctrl #(
    parameter int CNT_W        = 32,
    parameter bit USE_MEMREADY = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       imm_src,
    output logic [3:0]       alu_control,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        AUIPC    = 4'd12,
        TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_PASB = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state, state_nxt;
    logic       rdy;
    logic [3:0] alu_dec;
    logic       pc_write_s, mem_write_s, ir_write_s, reg_write_s;

    assign rdy = USE_MEMREADY ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            state <= state_nxt;
            if (state != FETCH && state_nxt == FETCH)
                instret <= instret + CNT_ONE;
        end
    end

    // funct7b5 selects sub only for register-register ops; shifts honour it in both forms
    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (state == EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_STORE:         imm_src = 3'b001;
            OP_BR:            imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        pc_write_s  = 1'b0;
        adr_src     = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        reg_write_s = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write_s = rdy;
                ir_write_s = rdy;
                state_nxt  = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                // unsupported funct3 encodings are trapped here so EXEC/BRANCH never see them
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = MEMADR;
                    OP_R:     state_nxt = (funct3 == 3'b011) ? TRAP : EXECR;
                    OP_I:     state_nxt = (funct3 == 3'b011) ? TRAP : EXECI;
                    OP_BR:    state_nxt = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
                    OP_JAL:   state_nxt = JAL;
                    OP_LUI:   state_nxt = LUI;
                    OP_AUIPC: state_nxt = AUIPC;
                    default:  state_nxt = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src   = 1'b1;
                state_nxt = rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
                state_nxt   = FETCH;
            end
            MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
                state_nxt   = rdy ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_dec;
                state_nxt   = ALUWB;
            end
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
                state_nxt   = ALUWB;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                state_nxt   = FETCH;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write_s  = zero ^ funct3[0];
                state_nxt   = FETCH;
            end
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_s = 1'b1;
                state_nxt  = ALUWB;
            end
            LUI: begin
                alu_src_b   = 2'b01;
                alu_control = ALU_PASB;
                state_nxt   = ALUWB;
            end
            AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_nxt = ALUWB;
            end
            TRAP:    state_nxt = TRAP;
            default: state_nxt = TRAP;
        endcase
    end

    // enables are forced low combinationally so an asserted reset kills a pending store at once
    assign pc_write  = pc_write_s  & ~reset;
    assign mem_write = mem_write_s & ~reset;
    assign ir_write  = ir_write_s  & ~reset;
    assign reg_write = reg_write_s & ~reset;
    assign illegal   = (state == TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl; instret is 3 bits wide here so the counter wraps.
module tb_multicycle_ctrl;
    localparam int CW = 3;

    logic          clk, reset, funct7b5, zero, mem_ready;
    logic [6:0]    op;
    logic [2:0]    funct3;
    logic          pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]    result_src, alu_src_a, alu_src_b;
    logic [2:0]    imm_src;
    logic [3:0]    alu_control;
    logic [CW-1:0] instret;
    logic [18:0]   obs;

    int n_pass  = 0;
    int n_total = 0;

    multicycle_ctrl #(.CNT_W(CW), .USE_MEMREADY(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .reg_write(reg_write), .illegal(illegal),
        .instret(instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, imm_src, alu_control, reg_write, illegal};

    function automatic logic [18:0] pk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic rw, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ill};
    endfunction

    function automatic logic [18:0] fetch_e(input logic rdy, input logic [2:0] imm);
        return pk(rdy, 1'b0, 1'b0, rdy, 2'b10, 2'b00, 2'b10, imm, 4'b0000, 1'b0, 1'b0);
    endfunction

    function automatic logic [18:0] decode_e(input logic [2:0] imm);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 4'b0000, 1'b0, 1'b0);
    endfunction

    function automatic logic [18:0] aluwb_e(input logic [2:0] imm);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 4'b0000, 1'b1, 1'b0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
    endtask

    task automatic chk(input string tag, input logic [18:0] exp);
        #1;
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_cnt(input string tag, input logic [CW-1:0] exp);
        n_total++;
        assert (instret === exp) n_pass++;
        else $error("FAIL %s: instret got %0d expected %0d", tag, instret, exp);
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
        ir(7'b0000000, 3'b000, 1'b0);
        #2;
        chk("reset_outs", pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 0, 0));
        chk_cnt("reset_instret", 3'd0);
        @(negedge clk);
        reset = 1'b0;

        // lw x5,4(x0): five cycles, reg_write only in the last
        ir(7'b0000011, 3'b010, 1'b0);
        chk("lw_fetch", fetch_e(1'b1, 3'b000));
        step(); chk("lw_decode", decode_e(3'b000));
        step(); chk("lw_memadr", pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 0, 0));
        step(); chk("lw_memread", pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 0, 0));
        step(); chk("lw_memwb", pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 4'b0000, 1, 0));
        step(); chk_cnt("lw_instret", 3'd1);

        // sw: one fetch stall, ready ignored in DECODE, three wait cycles in MEMWRITE
        ir(7'b0100011, 3'b010, 1'b0);
        mem_ready = 1'b0; chk("sw_fetch_stall", fetch_e(1'b0, 3'b001));
        step(); mem_ready = 1'b1; chk("sw_fetch", fetch_e(1'b1, 3'b001));
        step(); mem_ready = 1'b0; chk("sw_decode_rdy_ignored", decode_e(3'b001));
        step(); mem_ready = 1'b1;
        chk("sw_memadr", pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000, 0, 0));
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) mem_ready = 1'b1;
            chk("sw_memwrite", pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'b0000, 0, 0));
        end
        step(); chk_cnt("sw_instret", 3'd2);

        // beq taken, then bne with zero=1 not taken
        zero = 1'b1;
        ir(7'b1100011, 3'b000, 1'b0);
        chk("beq_fetch", fetch_e(1'b1, 3'b010));
        step(); chk("beq_decode", decode_e(3'b010));
        step(); chk("beq_branch", pk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 4'b0001, 0, 0));
        step(); chk_cnt("beq_instret", 3'd3);
        ir(7'b1100011, 3'b001, 1'b0);
        step(); step();
        chk("bne_branch", pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 4'b0001, 0, 0));
        step(); chk_cnt("bne_instret", 3'd4);

        // srai, addi with funct7b5 set, R-type sub
        ir(7'b0010011, 3'b101, 1'b1);
        step(); step();
        chk("srai_execi", pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'b1010, 0, 0));
        step(); chk("srai_aluwb", aluwb_e(3'b000));
        step(); chk_cnt("srai_instret", 3'd5);
        ir(7'b0010011, 3'b000, 1'b1);
        step(); step();
        chk("addi_execi", pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 0, 0));
        step(); step(); chk_cnt("addi_instret", 3'd6);
        ir(7'b0110011, 3'b000, 1'b1);
        step(); step();
        chk("sub_execr", pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0001, 0, 0));
        step(); step(); chk_cnt("sub_instret", 3'd7);

        // jal retires the eighth instruction: 3-bit counter wraps to 0
        ir(7'b1101111, 3'b000, 1'b0);
        step(); chk("jal_decode", decode_e(3'b011));
        step(); chk("jal_jal", pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b011, 4'b0000, 0, 0));
        step(); chk("jal_aluwb", aluwb_e(3'b011));
        step(); chk_cnt("jal_instret_wrap", 3'd0);
        ir(7'b0110111, 3'b000, 1'b0);
        step(); step();
        chk("lui_lui", pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b100, 4'b0111, 0, 0));
        step(); step(); chk_cnt("lui_instret", 3'd1);

        // unsupported opcode: TRAP is sticky regardless of mem_ready/zero
        ir(7'b0000000, 3'b000, 1'b0);
        chk("trap_fetch", fetch_e(1'b1, 3'b000));
        step(); chk("trap_decode", decode_e(3'b000));
        for (int i = 0; i < 20; i++) begin
            step();
            mem_ready = i[0];
            chk("trap_hold", pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 0, 1));
        end
        chk_cnt("trap_instret", 3'd1);
        reset = 1'b1; mem_ready = 1'b1;
        chk("trap_reset", pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 0, 0));
        chk_cnt("trap_reset_instret", 3'd0);
        step(); reset = 1'b0;

        // addi then sw aborted by reset inside MEMWRITE
        ir(7'b0010011, 3'b000, 1'b0);
        step(); step(); step(); step();
        chk_cnt("addi2_instret", 3'd1);
        ir(7'b0100011, 3'b010, 1'b0);
        step(); step(); step(); mem_ready = 1'b0;
        chk("rst_memwrite_pre", pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'b0000, 0, 0));
        reset = 1'b1;
        chk("rst_memwrite_drop", pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b001, 4'b0000, 0, 0));
        chk_cnt("rst_memwrite_instret", 3'd0);
        step(); reset = 1'b0; mem_ready = 1'b1;
        chk("post_rst_fetch", fetch_e(1'b1, 3'b001));
        step(); chk("post_rst_decode", decode_e(3'b001));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: sim time exceeded, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "timeout");
    end
endmodule
